pipelined_ctrl_unit: RTL

//  Registered successor to the combinational decoder. Decodes opcode/func in ID into a
//  10-bit control bundle and carries the bundle plus destination register through
//  NUM_STAGES pipeline registers (EX, MEM, ..., WB).

---
 rtl/pipelined_ctrl_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_ctrl_unit.sv
// Registered control unit: decodes ID into a 10-bit control bundle and carries it through the pipeline.
// It also generates the load-use stall, inserts flush bubbles and drains the pipeline on halt.
module pipelined_ctrl_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned LINK_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [5:0]            id_opcode,
  input  logic [5:0]            id_func,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush,
  output logic                  stall,
  output logic [9:0]            ex_ctrl,
  output logic [9:0]            mem_ctrl,
  output logic [9:0]            wb_ctrl,
  output logic [REG_ADDR_W-1:0] ex_wreg,
  output logic [REG_ADDR_W-1:0] mem_wreg,
  output logic [REG_ADDR_W-1:0] wb_wreg,
  output logic                  illegal,
  output logic                  halted
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;
  localparam int unsigned CNT_W = $clog2(NUM_STAGES + 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [9:0]            r_ctrl [NUM_STAGES];
  logic [REG_ADDR_W-1:0] r_wreg [NUM_STAGES];
  logic                  r_illegal;
  logic                  r_halted;

  logic [9:0]            w_dec;
  logic [REG_ADDR_W-1:0] w_wreg;
  logic                  w_illegal;
  logic                  w_is_halt;
  logic                  w_load_use;
  logic                  w_accept;

  always_comb begin
    w_dec     = '0;
    w_illegal = 1'b0;
    w_is_halt = 1'b0;
    if (id_valid) begin
      case (id_opcode)
        6'h00: begin
          case (id_func)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
              w_dec[4] = 1'b1;
              w_dec[5] = 1'b1;
            end
            6'h08:   w_dec[7] = 1'b1;
            default: w_illegal = 1'b1;
          endcase
        end
        6'h02: w_dec[7] = 1'b1;
        6'h03: begin
          w_dec[7] = 1'b1;
          w_dec[5] = 1'b1;
          w_dec[8] = 1'b1;
        end
        6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: begin
          w_dec[3] = 1'b1;
          w_dec[5] = 1'b1;
        end
        6'h04, 6'h05: w_dec[6] = 1'b1;
        6'h23: begin
          w_dec[1] = 1'b1;
          w_dec[2] = 1'b1;
          w_dec[3] = 1'b1;
          w_dec[5] = 1'b1;
        end
        6'h2B: begin
          w_dec[0] = 1'b1;
          w_dec[3] = 1'b1;
        end
        6'h3F: begin
          if (id_func == 6'h3F) w_is_halt = 1'b1;
          else                  w_illegal = 1'b1;
        end
        default: w_illegal = 1'b1;
      endcase
      w_dec[9] = 1'b1;
    end
  end

  always_comb begin
    w_wreg = '0;
    if (w_dec[5]) begin
      if (w_dec[8])      w_wreg = REG_ADDR_W'(LINK_REG);
      else if (w_dec[4]) w_wreg = id_rd;
      else               w_wreg = id_rt;
    end
  end

  assign w_load_use = r_ctrl[0][1] && (r_wreg[0] != '0) && id_valid &&
                      ((r_wreg[0] == id_rs) || (r_wreg[0] == id_rt));
  // Flush outranks both the hazard stall and the drain stall; stage0 bubbles either way.
  assign w_accept   = (r_state == S_RUN) && !flush && !w_load_use;
  assign stall      = !flush && (w_load_use || (r_state != S_RUN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        r_ctrl[k] <= '0;
        r_wreg[k] <= '0;
      end
      r_illegal <= 1'b0;
    end else begin
      r_ctrl[0] <= w_accept ? w_dec  : '0;
      r_wreg[0] <= w_accept ? w_wreg : '0;
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
        r_ctrl[k] <= r_ctrl[k-1];
        r_wreg[k] <= r_wreg[k-1];
      end
      r_illegal <= w_accept && w_illegal;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_accept && w_is_halt) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
          end
        end
        S_DRAIN: begin
          if (r_cnt == CNT_W'(NUM_STAGES - 1)) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HALTED: r_halted <= 1'b1;
        default:  r_state  <= S_RUN;
      endcase
    end
  end

  assign ex_ctrl  = r_ctrl[0];
  assign mem_ctrl = r_ctrl[1];
  assign wb_ctrl  = r_ctrl[NUM_STAGES-1];
  assign ex_wreg  = r_wreg[0];
  assign mem_wreg = r_wreg[1];
  assign wb_wreg  = r_wreg[NUM_STAGES-1];
  assign illegal  = r_illegal;
  assign halted   = r_halted;

endmodule
